// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FWFT FIFO using all DEPTH entries via pointer wrap
//            bits, with count, almost flags and flush. Optional sticky
//            overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN
//            is defined.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH:0] c_ptr_one      = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_depth        = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_afull_thresh = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_aempty_thresh = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  wr_acc;
    logic                  rd_acc;

    // All status is decoded from the registered pointers only.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (count == '0);
    assign full         = (count == c_depth);
    assign almost_empty = (count <= c_aempty_thresh);
    assign almost_full  = (count >= c_afull_thresh);
    assign rd_data      = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + c_ptr_one;
            if (rd_acc) rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; a flushed write must not land in memory.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en && full && !flush)  overflow_d  = 1'b1;
            if (rd_en && empty && !flush) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
`default_nettype wire
